// File: rtl/vga_pattern_gen.sv
// VGA test-pattern engine: solid / colour bars / checker background under a bouncing box,
// one-cycle registered RGB with matching sync delay. Box motion is built when VGA_PATTERN_BOUNCE_EN is defined.
module vga_pattern_gen #(
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned CW        = 10,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BOX_W     = 100,
    parameter int unsigned BOX_H     = 100,
    parameter int unsigned BOX_X0    = 101,
    parameter int unsigned BOX_Y0    = 101,
    parameter int unsigned STEP      = 2,
    parameter int unsigned CHK_SHIFT = 5,
    parameter logic [COLOR_W-1:0] FG_R = COLOR_W'(4'hF),
    parameter logic [COLOR_W-1:0] FG_G = COLOR_W'(4'h2),
    parameter logic [COLOR_W-1:0] FG_B = COLOR_W'(4'hF),
    parameter logic [COLOR_W-1:0] BG_R = COLOR_W'(4'h3),
    parameter logic [COLOR_W-1:0] BG_G = COLOR_W'(4'h6),
    parameter logic [COLOR_W-1:0] BG_B = COLOR_W'(4'h4)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CW-1:0]      x,
    input  logic [CW-1:0]      y,
    input  logic               video_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [1:0]         mode,
    input  logic               pause,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               hsync,
    output logic               vsync
);
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic          vs_prev;
    logic [1:0]    mode_q;
    logic          tick;
    logic [CW-1:0] box_x, box_y;

    assign tick = vs_prev & ~vsync_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev <= 1'b1;
            mode_q  <= 2'd0;
        end else begin
            vs_prev <= vsync_in;
            if (tick) mode_q <= mode;
        end
    end

`ifdef VGA_PATTERN_BOUNCE_EN
    logic dir_x, dir_y;

    // Returns {dir, pos} after one frame of motion along one axis.
    function automatic logic [CW:0] bounce(input logic [CW-1:0] pos, input logic dir,
                                           input int unsigned size, input int unsigned lim);
        logic [CW:0] pe;
        pe = {1'b0, pos};
        if (dir) begin
            if (pe + (CW+1)'(size + STEP) >= (CW+1)'(lim)) return {1'b0, CW'(lim - size)};
            else                                           return {1'b1, pos + CW'(STEP)};
        end else begin
            if (pe <= (CW+1)'(STEP)) return {1'b1, {CW{1'b0}}};
            else                     return {1'b0, pos - CW'(STEP)};
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x <= CW'(BOX_X0);
            box_y <= CW'(BOX_Y0);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (tick && !pause) begin
            {dir_x, box_x} <= bounce(box_x, dir_x, BOX_W, H_ACTIVE);
            {dir_y, box_y} <= bounce(box_y, dir_y, BOX_H, V_ACTIVE);
        end
    end
`else
    assign box_x = CW'(BOX_X0);
    assign box_y = CW'(BOX_Y0);
`endif

    logic [CW:0] xe, ye, bxe, bye;
    logic        in_box;

    assign xe     = {1'b0, x};
    assign ye     = {1'b0, y};
    assign bxe    = {1'b0, box_x};
    assign bye    = {1'b0, box_y};
    assign in_box = (xe >= bxe) && (xe < bxe + (CW+1)'(BOX_W)) &&
                    (ye >= bye) && (ye < bye + (CW+1)'(BOX_H));

    // Bar index by constant thresholds; 8 means past the last full bar (black).
    logic [3:0] bar_idx;
    logic [2:0] bar_rgb;
    always_comb begin
        bar_idx = 4'd8;
        for (int k = 7; k >= 0; k--)
            if (xe < (CW+1)'((k + 1) * BAR_W)) bar_idx = 4'(k);
        bar_rgb = bar_idx[3] ? 3'b000 : ~bar_idx[2:0];
    end

    logic [COLOR_W-1:0] r_n, g_n, b_n;
    always_comb begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
        if (video_on && mode_q != 2'd3) begin
            if (in_box) begin
                r_n = FG_R; g_n = FG_G; b_n = FG_B;
            end else begin
                case (mode_q)
                    2'd0: begin r_n = BG_R; g_n = BG_G; b_n = BG_B; end
                    2'd1: begin
                        r_n = {COLOR_W{bar_rgb[2]}};
                        g_n = {COLOR_W{bar_rgb[1]}};
                        b_n = {COLOR_W{bar_rgb[0]}};
                    end
                    default: begin
                        r_n = {COLOR_W{x[CHK_SHIFT] ^ y[CHK_SHIFT]}};
                        g_n = r_n;
                        b_n = r_n;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            red   <= r_n;
            green <= g_n;
            blue  <= b_n;
            hsync <= hsync_in;
            vsync <= vsync_in;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen against a frame-level behavioural model,
// plus directed pixel checks; honours VGA_PATTERN_BOUNCE_EN like the design.
module tb_vga_pattern_gen;
    localparam int H = 640, V = 480, BW = 100, BH = 100, X0 = 536, Y0 = 101, ST = 2;

    logic       clk = 0, reset = 1;
    logic [9:0] x = 0, y = 0;
    logic       video_on = 0, hsync_in = 1, vsync_in = 1, pause = 0;
    logic [1:0] mode = 0;
    logic [3:0] red, green, blue;
    logic       hsync, vsync;

    vga_pattern_gen #(.BOX_X0(X0), .BOX_Y0(Y0)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .mode(mode), .pause(pause),
        .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int m_bx, m_by, m_dx, m_dy, m_mq, m_vsp;
    logic [13:0] obs, exp_v;
    int cur_mode = 0;
    logic cur_pause = 0;

    function automatic void m_reset();
        m_bx = X0; m_by = Y0; m_dx = 1; m_dy = 1; m_mq = 0; m_vsp = 1;
    endfunction

    function automatic logic [11:0] ref_pix(int px, int py, logic vo);
        int i, c;
        if (!vo || m_mq == 3) return 12'h000;
        if (px >= m_bx && px < m_bx + BW && py >= m_by && py < m_by + BH) return 12'hF2F;
        case (m_mq)
            0: return 12'h364;
            1: begin
                i = px / (H / 8);
                if (i >= 8) return 12'h000;
                c = 7 - i;
                return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
            end
            default: return (((px >> 5) ^ (py >> 5)) & 1) != 0 ? 12'hFFF : 12'h000;
        endcase
    endfunction

    function automatic void axis_move(inout int p, inout int d, input int sz, input int lim);
        if (d == 1) begin
            if (p + sz + ST >= lim) begin p = lim - sz; d = 0; end
            else p = p + ST;
        end else begin
            if (p <= ST) begin p = 0; d = 1; end
            else p = p - ST;
        end
    endfunction

    // Drive one pixel cycle, predict its registered output, check it after the edge.
    task automatic step(input int px, input int py, input logic vo, input logic hs,
                        input logic vs, input int md, input logic ps, input string tag);
        x = 10'(px); y = 10'(py); video_on = vo; hsync_in = hs; vsync_in = vs;
        mode = 2'(md); pause = ps;
        exp_v = {ref_pix(px, py, vo), hs, vs};
        if (m_vsp == 1 && vs == 0) begin
            m_mq = md;
`ifdef VGA_PATTERN_BOUNCE_EN
            if (!ps) begin
                axis_move(m_bx, m_dx, BW, H);
                axis_move(m_by, m_dy, BH, V);
            end
`endif
        end
        m_vsp = vs;
        @(posedge clk);
        @(negedge clk);
        obs = {red, green, blue, hsync, vsync};
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s x=%0d y=%0d obs=%h exp=%h", tag, px, py, obs, exp_v);
        end
    endtask

    task automatic check_const(input logic [13:0] want, input string tag);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, want);
        end
    endtask

    function automatic int pick(int lo_edge, int size, int span);
        int r, v;
        r = int'($urandom_range(0, 5));
        case (r)
            0: v = lo_edge - 1;
            1: v = lo_edge;
            2: v = lo_edge + size - 1;
            3: v = lo_edge + size;
            default: v = int'($urandom_range(0, span));
        endcase
        return v < 0 ? 0 : (v > 1023 ? 1023 : v);
    endfunction

    task automatic rand_frame(input int npix);
        step(pick(m_bx, BW, 700), pick(m_by, BH, 520), 1'b1, 1'($urandom), 1'b0,
             cur_mode, cur_pause, "tick");
        for (int k = 0; k < npix; k++) begin
            if ($urandom_range(0, 3) == 0) cur_mode = int'($urandom_range(0, 3));
            step(pick(m_bx, BW, 700), pick(m_by, BH, 520), ($urandom_range(0, 7) != 0),
                 1'($urandom), 1'b1, cur_mode, cur_pause, "rand");
        end
    endtask

    task automatic check_reset_outs(input string tag);
        obs = {red, green, blue, hsync, vsync};
        check_const(14'b0000_0000_0000_11, tag);
    endtask

    initial begin
        m_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outs("reset_hold");
        reset = 0;

        step(560, 150, 1, 1, 1, 0, 0, "fg");        check_const({12'hF2F, 2'b11}, "fg_const");
        step(50, 150, 1, 1, 1, 0, 0, "bg");         check_const({12'h364, 2'b11}, "bg_const");
        step(560, 150, 0, 1, 1, 0, 0, "blank_vo");  check_const({12'h000, 2'b11}, "blank_const");
        step(50, 150, 1, 0, 1, 0, 0, "hs_lo");      check_const({12'h364, 2'b01}, "hsync_delay");
        step(50, 150, 1, 1, 1, 0, 0, "hs_hi");      check_const({12'h364, 2'b11}, "hsync_release");

        // Mode request mid-frame must not take effect until the vsync fall.
        step(50, 300, 1, 1, 1, 1, 0, "mode_req");   check_const({12'h364, 2'b11}, "no_tear");
        step(50, 300, 1, 1, 0, 1, 0, "tick_m1");    check_const({12'h364, 2'b10}, "tick_cycle_old");
        step(0, 300, 1, 1, 1, 1, 0, "bar0");        check_const({12'hFFF, 2'b11}, "bar_white");
        step(600, 300, 1, 1, 1, 1, 0, "bar7");      check_const({12'h000, 2'b11}, "bar_black");
        step(85, 300, 1, 1, 1, 1, 0, "bar1");       check_const({12'hFF0, 2'b11}, "bar_yellow");
        step(639, 300, 1, 1, 1, 1, 0, "bar_last");
        step(50, 300, 1, 1, 0, 2, 0, "tick_m2");
        step(0, 0, 1, 1, 1, 2, 0, "chk00");         check_const({12'h000, 2'b11}, "chk_black");
        step(32, 0, 1, 1, 1, 2, 0, "chk32");        check_const({12'hFFF, 2'b11}, "chk_white");

        // Long run: covers right/left and top/bottom bounces with random modes.
        cur_mode = 0;
        for (int f = 0; f < 650; f++) rand_frame(4);

        cur_pause = 1;
        for (int f = 0; f < 3; f++) rand_frame(6);
        cur_pause = 0;
        for (int f = 0; f < 5; f++) rand_frame(4);

        @(negedge clk);
        reset = 1;
        #1;
        check_reset_outs("reset_mid");
        m_reset();
        @(negedge clk);
        check_reset_outs("reset_mid_hold");
        reset = 0;
        step(536, 150, 1, 1, 1, 3, 0, "post_rst_fg");  check_const({12'hF2F, 2'b11}, "box_at_x0");
        step(535, 150, 1, 1, 1, 3, 0, "post_rst_bg");  check_const({12'h364, 2'b11}, "mode_q_cleared");
        cur_mode = 0;
        for (int f = 0; f < 20; f++) rand_frame(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
